// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared ALU.
//
// A grant in IDLE registers the winner's operands, which are presented to
// the external ALU for exactly one EXEC cycle. The ALU result is captured
// into a response register that is held in RESP until the consumer takes it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_fun   requester N operands and function code
//   aluA, aluB, alufun         operands to the shared ALU (0 outside EXEC)
//   valE                       combinational result from the shared ALU
//   rsp_valid / rsp_ready      response handshake toward the consumer
//   rsp_id, rsp_data, rsp_err  owner, result value, illegal-code flag
//   busy                       high while an operation is in EXEC or RESP
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_fun,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_fun,
  output logic [31:0] aluA,
  output logic [31:0] aluB,
  output logic [3:0]  alufun,
  input  logic [31:0] valE,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        ptr_q;
  logic        id_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_fun_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        busy_q;

  logic        gnt_any_s;
  logic        gnt_id_s;
  logic [31:0] op_a_d;
  logic [31:0] op_b_d;
  logic [3:0]  op_fun_d;
  logic        illegal_s;

  // Codes above 3 have no ALU meaning; their result is suppressed.
  function automatic logic fun_illegal(input logic [3:0] fun);
    return (fun > 4'd3);
  endfunction

  // Arbitration: a lone requester wins, a tie goes to the requester at ptr.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_id_s  = 1'b0;
    if (state_q == ST_IDLE) begin
      gnt_any_s = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
        gnt_id_s = ptr_q;
      end else begin
        gnt_id_s = req1_valid;
      end
    end else begin
      gnt_any_s = 1'b0;
      gnt_id_s  = 1'b0;
    end
  end

  // Operand mux feeding the EXEC registers from the winning requester.
  always_comb begin
    op_a_d   = 32'd0;
    op_b_d   = 32'd0;
    op_fun_d = 4'd0;
    if (gnt_id_s) begin
      op_a_d   = req1_a;
      op_b_d   = req1_b;
      op_fun_d = req1_fun;
    end else begin
      op_a_d   = req0_a;
      op_b_d   = req0_b;
      op_fun_d = req0_fun;
    end
  end

  assign illegal_s = fun_illegal(alu_fun_q);

  // ready is combinational and gated by rst_n so it stays low during reset.
  assign req0_ready = rst_n & gnt_any_s & ~gnt_id_s;
  assign req1_ready = rst_n & gnt_any_s & gnt_id_s;

  // Control FSM with all outputs registered; reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_fun_q   <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_any_s) begin
            alu_a_q   <= op_a_d;
            alu_b_q   <= op_b_d;
            alu_fun_q <= op_fun_d;
            id_q      <= gnt_id_s;
            // Loser of this round gets priority at the next tie.
            ptr_q     <= ~gnt_id_s;
            busy_q    <= 1'b1;
            state_q   <= ST_EXEC;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= illegal_s ? 32'd0 : valE;
          rsp_err_q   <= illegal_s;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          // ALU inputs are only meaningful during EXEC.
          alu_a_q     <= 32'd0;
          alu_b_q     <= 32'd0;
          alu_fun_q   <= 4'd0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q     <= ST_RESP;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          alu_a_q     <= 32'd0;
          alu_b_q     <= 32'd0;
          alu_fun_q   <= 4'd0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign aluA      = alu_a_q;
  assign aluB      = alu_b_q;
  assign alufun    = alu_fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter. The bench also plays the external ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_fun, req1_fun;
  logic [31:0] aluA, aluB, valE, rsp_data;
  logic [3:0]  alufun;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  int   vecs  = 0;
  int   fails = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  bit   id_q[$];

  // reference-model state (transaction level)
  bit          m_free = 1'b1;
  bit          free_next = 1'b0;
  bit          m_ptr = 1'b0;
  int          cyc = 0;
  int          grant_cyc = -100;
  int          gcount = 0;
  logic [31:0] g_a, g_b;
  logic [3:0]  g_fun;
  exp_t        cur;
  bit          cur_id;
  bit          acc0 = 1'b0, acc1 = 1'b0;
  bit          e_any, e_id, in_exec;

  always #5 clk = ~clk;

  // Behaviour of the external ALU; codes >3 yield junk so forcing to 0 is visible.
  function automatic logic [31:0] spec_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return {31'd0, (a != 32'd0) && (b != 32'd0)};
      4'd3:    return {31'd0, (a != 32'd0) ^ (b != 32'd0)};
      default: return a ^ b ^ 32'hA5A5_0000;
    endcase
  endfunction

  always_comb valE = spec_alu(aluA, aluB, alufun);

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fun(req1_fun),
    .aluA(aluA), .aluB(aluB), .alufun(alufun), .valE(valE),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic sb_fail(input string nm);
    vecs++;
    fails++;
    $display("FAIL %s: got condition not met, expected it met (t=%0t)", nm, $time);
  endtask

  // Monitor: predicts every output from the model and pops expected results.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_free = 1'b1; free_next = 1'b0; m_ptr = 1'b0;
      cyc = 0; grant_cyc = -100; id_q.delete();
      acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      cyc++;
      if (free_next) begin
        m_free = 1'b1;
        free_next = 1'b0;
      end
      e_any = m_free && (req0_valid || req1_valid);
      e_id  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      chk("req0_ready", req0_ready, e_any && !e_id);
      chk("req1_ready", req1_ready, e_any && e_id);
      in_exec = !m_free && (cyc == grant_cyc + 1);
      chk("aluA", aluA, in_exec ? g_a : 32'd0);
      chk("aluB", aluB, in_exec ? g_b : 32'd0);
      chk("alufun", alufun, in_exec ? g_fun : 4'd0);
      chk("busy", busy, !m_free && (cyc > grant_cyc));
      chk("rsp_valid", rsp_valid, !m_free && (cyc >= grant_cyc + 2));
      if (!m_free && (cyc >= grant_cyc + 2) && rsp_valid) begin
        if (cyc == grant_cyc + 2) begin
          if (id_q.size() == 0) begin
            sb_fail("sb_no_grant");
          end else begin
            cur_id = id_q.pop_front();
            if (!cur_id && exp_q0.size() != 0) cur = exp_q0.pop_front();
            else if (cur_id && exp_q1.size() != 0) cur = exp_q1.pop_front();
            else sb_fail("sb_empty");
          end
        end
        chk("rsp_id", rsp_id, cur_id);
        chk("rsp_data", rsp_data, cur.data);
        chk("rsp_err", rsp_err, cur.err);
        if (rsp_ready) free_next = 1'b1;
      end
      if (e_any) begin
        g_a   = e_id ? req1_a : req0_a;
        g_b   = e_id ? req1_b : req0_b;
        g_fun = e_id ? req1_fun : req0_fun;
        id_q.push_back(e_id);
        m_ptr = !e_id;
        m_free = 1'b0;
        grant_cyc = cyc;
        gcount++;
      end
      acc0 = req0_ready;
      acc1 = req1_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
  endtask

  // Raise a request and record its expected response from the function rules.
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f);
    exp_t e;
    e.err  = (f > 4'd3);
    e.data = e.err ? 32'd0 : spec_alu(a, b, f);
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fun = f;
      exp_q0.push_back(e);
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fun = f;
      exp_q1.push_back(e);
    end
  endtask

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 32'd0;
    return $urandom();
  endfunction

  task automatic issue_rand(input int n);
    issue(n, rand_op(), rand_op(), 4'($urandom_range(0, 5)));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((req0_valid || req1_valid || exp_q0.size() != 0 || exp_q1.size() != 0 ||
            !m_free || free_next) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) sb_fail("drain_timeout");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_aluA"}, aluA, 32'd0);
    chk({tag, "_aluB"}, aluB, 32'd0);
    chk({tag, "_alufun"}, alufun, 4'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_id"}, rsp_id, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_a = 32'd0; req0_b = 32'd0; req0_fun = 4'd0;
    req1_a = 32'd0; req1_b = 32'd0; req1_fun = 4'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    chk_all_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // single add and the remaining legal codes
    issue(0, 32'hBE, 32'hAA, 4'd0);
    wait_drain(20);
    for (int f = 1; f <= 3; f++) begin
      issue(1, 32'hBE, 32'hAA, 4'(f));
      wait_drain(20);
    end

    // illegal code
    issue(0, 32'd1, 32'd1, 4'd4);
    wait_drain(20);

    // contention with both requesters valid straight out of reset
    rst_n = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    issue_rand(0);
    issue_rand(1);
    repeat (2) tick();
    rst_n = 1'b1;
    base = gcount;
    n = 0;
    while (gcount < base + 4 && n < 100) begin
      tick();
      if (gcount < base + 4) begin
        if (!req0_valid) issue_rand(0);
        if (!req1_valid) issue_rand(1);
      end
      n++;
    end
    if (n >= 100) sb_fail("contention_timeout");
    wait_drain(60);

    // backpressure
    rsp_ready = 1'b0;
    issue_rand(1);
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    if (!rsp_valid) sb_fail("bp_no_rsp");
    issue_rand(0);
    repeat (5) tick();
    chk("bp_busy", busy, 1'b1);
    chk("bp_req0_ready", req0_ready, 1'b0);
    rsp_ready = 1'b1;
    wait_drain(20);

    // reset during EXEC of a req0 operation (ptr then points at 1)
    issue_rand(0);
    tick();
    chk("exec_busy", busy, 1'b1);
    req1_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    issue_rand(0);
    issue_rand(1);
    @(negedge clk);
    chk("post_rst_req0_ready", req0_ready, 1'b1);
    chk("post_rst_req1_ready", req1_ready, 1'b0);
    wait_drain(40);

    // randomized traffic with random consumer stalls
    repeat (400) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid && $urandom_range(0, 2) == 0) issue_rand(0);
      if (!req1_valid && $urandom_range(0, 2) == 0) issue_rand(1);
    end
    rsp_ready = 1'b1;
    wait_drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the single clock and rst_n is the asynchronous active-low reset.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  32  requester 0 operands.
- req0_fun  in  4  requester 0 ALU function code.
- req1_valid, req1_ready, req1_a, req1_b, req1_fun: same as requester 0, for requester 1.
- aluA, aluB  out  32  operands to the shared alu instance.
- alufun  out  4  function code to the shared alu instance.
- valE  in  32  combinational result from the shared alu instance.
- rsp_valid  out  1  a result is held for the consumer.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  32  result value.
- rsp_err  out  1  function code was illegal (>3).
- busy  out  1  state is not IDLE.

Function
REQ-003 The block SHALL implement three states, IDLE, EXEC and RESP, with a 1-bit round-robin pointer ptr.
REQ-004 In IDLE, if exactly one reqN_valid is high, that requester SHALL be granted; if both are high, requester ptr SHALL be granted.
REQ-005 reqN_ready SHALL be high only in IDLE, combinationally, for the granted requester; it SHALL never be high for both requesters at once or in any other state.
REQ-006 On a grant edge, the block SHALL register the granted operands, function code and id, set ptr to the non-granted index, and enter EXEC.
REQ-007 In EXEC, aluA, aluB and alufun SHALL drive the registered values; in every other state they SHALL be 0.
REQ-008 At the end of EXEC (exactly one cycle), the block SHALL capture valE into rsp_data, set rsp_err = (fun > 3), and enter RESP.
REQ-009 When fun > 3, rsp_data SHALL be forced to 0 regardless of valE.
REQ-010 In RESP, rsp_valid SHALL be 1 and rsp_id, rsp_data and rsp_err SHALL be held stable until rsp_valid && rsp_ready.
REQ-011 On that handshake edge the block SHALL return to IDLE, so a new grant is possible on the following cycle; throughput is therefore at most one operation per 3 cycles.
REQ-012 Request-to-response latency SHALL be: grant edge, plus 1 cycle of EXEC, then rsp_valid asserted on the 2nd edge after the grant.
REQ-013 Requester inputs SHALL be ignored outside IDLE; a requester holds valid until it sees ready.
REQ-014 ptr SHALL NOT change on cycles without a grant.
REQ-015 busy SHALL be 1 in EXEC and RESP.
REQ-016 Function codes SHALL have the following meanings, realised by the external alu and relied on for checking:
- 0: A+B, modulo 2^32.
- 1: A-B, modulo 2^32.
- 2: logical AND, result 0 or 1.
- 3: logical XOR of (A!=0) and (B!=0), result 0 or 1.

Reset
REQ-017 When rst_n is low, the block SHALL asynchronously enter IDLE and set ptr=0 and rsp_valid, rsp_id, rsp_data, rsp_err, busy, aluA, aluB and alufun all to 0.
REQ-018 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-019 A reset asserted mid-operation (in EXEC or RESP) SHALL discard the operation with no response produced.
REQ-020 After rst_n deasserts, the first grant SHALL follow the normal IDLE rules.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Single add: req0 a=0xBE, b=0xAA, fun=0 -> req0_ready in the same cycle; alufun=0 in EXEC; rsp_valid 2 edges later; rsp_data=0x168, rsp_id=0, rsp_err=0.
- Sequential functions: req1 with a=0xBE, b=0xAA for fun=1, 2, 3 in turn -> rsp_data=0x14, then 0x1, then 0x0; rsp_id=1 each time.
- Contention: both requesters valid continuously from reset -> grant order 0, 1, 0, 1; never both ready in one cycle.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_* stable, busy=1, no new ready; rsp_ready=1 -> IDLE on the next edge, then a grant on the following cycle.
- Illegal code: fun=4 with a=1, b=1 -> rsp_err=1, rsp_data=0.
- Reset mid-operation: rst_n low during EXEC -> outputs 0 immediately; after release no stale rsp_valid; the next contended grant goes to requester 0.
